// File: rtl/mac_pkg.sv
// Shared definitions for the multiply-accumulate datapath: FSM states and
// signed saturation helpers that both the multiplier and accumulator can use.
package mac_pkg;

   typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

   typedef logic signed [63:0] wide_t;

   function automatic wide_t signed_max(input int width);
      return (wide_t'(1) <<< (width - 1)) - wide_t'(1);
   endfunction

   function automatic wide_t signed_min(input int width);
      return -(wide_t'(1) <<< (width - 1));
   endfunction

   // Clamp a wide signed value into the range of a narrower signed word.
   function automatic wide_t sat_clamp(input wide_t value, input int width);
      wide_t clamped;
      clamped = value;
      if (value > signed_max(width)) begin
         clamped = signed_max(width);
      end else if (value < signed_min(width)) begin
         clamped = signed_min(width);
      end
      return clamped;
   endfunction

endpackage

// File: rtl/mac_accumulator_if.sv
// Start/term/result bundle between the accumulator and its producer/consumer.
interface mac_accumulator_if #(
   parameter int IN_WIDTH  = 16,
   parameter int OUT_WIDTH = 16,
   parameter int LEN_WIDTH = 8
);

   logic                        start;
   logic [LEN_WIDTH-1:0]        len;
   logic                        in_valid;
   logic signed [IN_WIDTH-1:0]  in_data;
   logic                        busy;
   logic                        out_valid;
   logic                        out_ready;
   logic signed [OUT_WIDTH-1:0] out_data;
   logic                        out_sat;

   modport master (
      output start, len, in_valid, in_data, out_ready,
      input  busy, out_valid, out_data, out_sat
   );

   modport slave (
      input  start, len, in_valid, in_data, out_ready,
      output busy, out_valid, out_data, out_sat
   );

endinterface

// File: rtl/mac_accumulator_sat_convert.sv
// Converts the accumulator word to the output fixed-point format: arithmetic
// right shift (truncating toward -inf) followed by a signed clamp.
module sat_convert
   import mac_pkg::*;
#(
   parameter int ACC_WIDTH = 32,
   parameter int IN_FRAC   = 8,
   parameter int OUT_WIDTH = 16,
   parameter int OUT_FRAC  = 8
) (
   input  logic signed [ACC_WIDTH-1:0] acc_value,
   output logic signed [OUT_WIDTH-1:0] out_value,
   output logic                        clamped
);

   localparam int SHIFT = IN_FRAC - OUT_FRAC;

   wide_t shifted;
   wide_t limited;

   // Widen before shifting so the sign is preserved, then clamp to the output word.
   always_comb begin
      shifted   = wide_t'(acc_value) >>> SHIFT;
      limited   = sat_clamp(shifted, OUT_WIDTH);
      out_value = OUT_WIDTH'(limited);
      clamped   = (limited != shifted);
   end

endmodule

// File: rtl/mac_accumulator.sv
// Saturating accumulator that sums a programmed number of signed products and
// holds the converted result on a valid/ready port; freezes with the multiplier.
module mac_accumulator
   import mac_pkg::*;
#(
   parameter int IN_WIDTH  = 16,
   parameter int IN_FRAC   = 8,
   parameter int ACC_WIDTH = 32,
   parameter int OUT_WIDTH = 16,
   parameter int OUT_FRAC  = 8,
   parameter int LEN_WIDTH = 8
) (
   input logic              clk,
   input logic              reset,
   input logic              stall,
   mac_accumulator_if.slave bus
);

   state_t                      state;
   state_t                      state_next;
   logic signed [ACC_WIDTH-1:0] acc;
   logic signed [ACC_WIDTH-1:0] acc_next;
   logic signed [ACC_WIDTH-1:0] acc_sum_sat;
   logic [LEN_WIDTH-1:0]        cnt;
   logic [LEN_WIDTH-1:0]        cnt_next;
   logic                        sat_flag;
   logic                        sat_flag_next;
   logic signed [OUT_WIDTH-1:0] out_data_r;
   logic signed [OUT_WIDTH-1:0] out_data_next;
   logic signed [OUT_WIDTH-1:0] conv_value;
   logic                        out_sat_r;
   logic                        out_sat_next;
   logic                        conv_clamped;
   logic                        acc_clamped;
   wide_t                       acc_sum;
   wide_t                       acc_sum_limited;

   // Candidate accumulator value if the current term were accepted.
   always_comb begin
      acc_sum         = wide_t'(acc) + wide_t'(bus.in_data);
      acc_sum_limited = sat_clamp(acc_sum, ACC_WIDTH);
      acc_sum_sat     = ACC_WIDTH'(acc_sum_limited);
      acc_clamped     = (acc_sum_limited != acc_sum);
   end

   // Converting the post-add value lets the result load on the final term's edge.
   sat_convert #(
      .ACC_WIDTH (ACC_WIDTH),
      .IN_FRAC   (IN_FRAC),
      .OUT_WIDTH (OUT_WIDTH),
      .OUT_FRAC  (OUT_FRAC)
   ) u_convert (
      .acc_value (acc_sum_sat),
      .out_value (conv_value),
      .clamped   (conv_clamped)
   );

   always_comb begin
      state_next    = state;
      acc_next      = acc;
      cnt_next      = cnt;
      sat_flag_next = sat_flag;
      out_data_next = out_data_r;
      out_sat_next  = out_sat_r;
      unique case (state)
         IDLE: begin
            if (bus.start) begin
               if (bus.len != '0) begin
                  acc_next      = '0;
                  cnt_next      = bus.len;
                  sat_flag_next = 1'b0;
                  state_next    = ACCUM;
               end else begin
                  out_data_next = '0;
                  out_sat_next  = 1'b0;
                  state_next    = HOLD;
               end
            end
         end
         ACCUM: begin
            if (bus.in_valid) begin
               acc_next      = acc_sum_sat;
               cnt_next      = cnt - LEN_WIDTH'(1);
               sat_flag_next = sat_flag | acc_clamped;
               if (cnt == LEN_WIDTH'(1)) begin
                  out_data_next = conv_value;
                  out_sat_next  = sat_flag | acc_clamped | conv_clamped;
                  state_next    = HOLD;
               end
            end
         end
         HOLD: begin
            if (bus.out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Stall freezes every register; reset still takes priority.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         acc        <= '0;
         cnt        <= '0;
         sat_flag   <= 1'b0;
         out_data_r <= '0;
         out_sat_r  <= 1'b0;
      end else if (!stall) begin
         state      <= state_next;
         acc        <= acc_next;
         cnt        <= cnt_next;
         sat_flag   <= sat_flag_next;
         out_data_r <= out_data_next;
         out_sat_r  <= out_sat_next;
      end
   end

   assign bus.busy      = (state != IDLE);
   assign bus.out_valid = (state == HOLD);
   assign bus.out_data  = out_data_r;
   assign bus.out_sat   = out_sat_r;

endmodule
